// File: rtl/bit_serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_pkg
// Brief    : Op codes and FSM state encoding shared by the bit-serial ALU.
// Revision : 1.0 - initial release
// ============================================================================
package bit_serial_alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_serial_alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_bit_slice
// Brief    : Combinational 1-bit ALU slice (AND / OR / ADD, SUB as ADD).
//            Option macro: BIT_SERIAL_ALU_SUB_EN (op 6 handled as ADD).
// Revision : 1.0 - initial release
// ============================================================================
module alu_bit_slice
  import bit_serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);

  // Logic ops and unused codes never produce a carry.
  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
`ifdef BIT_SERIAL_ALU_SUB_EN
      // B was already inverted at accept, so subtract is a plain add here.
      OP_SUB: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
`endif
      default: begin
        res  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu
// Brief    : WIDTH-bit ALU evaluated one bit per clock, LSB first, through a
//            single alu_bit_slice. Valid/ready on both command and result.
//            Option macro: BIT_SERIAL_ALU_SUB_EN enables op 6 (SUB).
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu
  import bit_serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_r;
  logic             carry;
  logic [WIDTH-1:0] res_r;
  logic [CNT_W-1:0] cnt;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] b_entry;
  logic             carry_entry;

  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_r),
    .res  (slice_res),
    .cout (slice_cout)
  );

`ifdef BIT_SERIAL_ALU_SUB_EN
  // Subtract is computed as A + ~B + 1.
  assign b_entry     = (op == OP_SUB) ? ~b : b;
  assign carry_entry = (op == OP_SUB);
`else
  assign b_entry     = b;
  assign carry_entry = 1'b0;
`endif

  // Handshake outputs decode only from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign result    = res_r;
  assign cout      = carry;

  // Command FSM: accept, shift WIDTH bits through the slice, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      op_r  <= OP_AND;
      carry <= 1'b0;
      res_r <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_entry;
            op_r  <= op;
            carry <= carry_entry;
            res_r <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the first (LSB) ends at bit 0.
          res_r <= {slice_res, res_r[WIDTH-1:1]};
          carry <= slice_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_alu
// Brief    : Self-checking bench for bit_serial_alu (WIDTH=8), scoreboard
//            queue of expected {cout, result}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] sb_q[$];

  always #5 clk = ~clk;

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: {cout, result}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic [2:0] mop);
    logic [WIDTH:0] r;
    r = '0;
    case (mop)
      3'd0: r = {1'b0, ma & mb};
      3'd1: r = {1'b0, ma | mb};
      3'd2: r = {1'b0, ma} + {1'b0, mb};
`ifdef BIT_SERIAL_ALU_SUB_EN
      3'd6: r = {1'b0, ma} + {1'b0, ~mb} + 1'b1;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one command from IDLE, check latency and result, optionally stall
  // the sink for `hold` cycles with a competing command on the input.
  task automatic run_cmd(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic [2:0] top, input int hold);
    int lat;
    logic busy_ok;
    logic stall_ok;
    logic [WIDTH:0] exp;
    check_eq("ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; a = ta; b = tb; op = top;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model(ta, tb, top));
    check_eq("ready_after_accept", in_ready, 1'b0);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      busy_ok = busy_ok & busy & ~in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, WIDTH);
    check_eq("busy_in_run", busy_ok, 1'b1);
    exp = sb_q.pop_front();
    check_eq("result", result, exp[WIDTH-1:0]);
    check_eq("cout", cout, exp[WIDTH]);
    if (hold > 0) begin
      in_valid = 1'b1; a = ~ta; b = ~tb; op = 3'd2;
      stall_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        stall_ok = stall_ok & (result == exp[WIDTH-1:0]) & (cout == exp[WIDTH])
                   & out_valid & busy & ~in_ready;
      end
      check_eq("stall_hold", stall_ok, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_eq("handoff_out_valid", out_valid, 1'b0);
    check_eq("handoff_in_ready", in_ready, 1'b1);
    check_eq("handoff_busy", busy, 1'b0);
    check_eq("result_after_done", {cout, result}, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       rop;
    logic             quiet;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_result", result, 8'h00);
    check_eq("reset_cout", cout, 1'b0);
    check_eq("reset_in_ready", in_ready, 1'b1);

    run_cmd(8'hFF, 8'h01, 3'd2, 0);   // ADD wrap, carry out
    run_cmd(8'hF0, 8'h3C, 3'd0, 0);   // AND
    run_cmd(8'hF0, 8'h3C, 3'd1, 0);   // OR
    run_cmd(8'h05, 8'h07, 3'd6, 0);   // SUB borrow (or unused without macro)
    run_cmd(8'h07, 8'h05, 3'd6, 0);   // SUB no borrow
    run_cmd(8'hAA, 8'h55, 3'd3, 0);   // unused op
    run_cmd(8'h81, 8'h7F, 3'd2, 5);   // sink stall with competing command

    // Reset during the third RUN cycle discards the command.
    in_valid = 1'b1; a = 8'h99; b = 8'h77; op = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model(8'h99, 8'h77, 3'd2));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    check_eq("midreset_out_valid", out_valid, 1'b0);
    check_eq("midreset_result", result, 8'h00);
    check_eq("midreset_in_ready", in_ready, 1'b1);
    check_eq("midreset_busy", busy, 1'b0);
    quiet = 1'b1;
    repeat (WIDTH + 3) begin
      @(posedge clk); #1;
      quiet = quiet & ~out_valid & in_ready;
    end
    check_eq("midreset_no_output", quiet, 1'b1);
    run_cmd(8'h12, 8'h34, 3'd2, 0);

    // A few random commands across the defined and unused codes.
    for (int i = 0; i < 6; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      run_cmd(ra, rb, rop, i % 2);
    end

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
